// File: rtl/matrix_frame_ctrl.sv
// Scan-clock generator and double-buffered frame store for the 8x8 red/green LED matrix.
// Writers fill the back buffer row by row; a commit publishes it to the front buffer at the next frame boundary.
module matrix_frame_ctrl #(
    parameter int CLK_DIV = 50000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_valid,
    output logic         wr_ready,
    input  logic [2:0]   wr_row,
    input  logic [15:0]  wr_data,
    input  logic         commit,
    output logic         busy,
    input  logic         blank,
    output logic         scan_clk,
    output logic         frame_tick,
    output logic [127:0] data_out
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    // Handshake: a row write transfers on a rising clk edge where wr_valid && wr_ready;
    // the writer must hold wr_row/wr_data stable while wr_valid is high and wr_ready is low.

    typedef enum logic {
        IDLE      = 1'b0,
        SWAP_PEND = 1'b1
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [CW-1:0]  cnt;
    logic [2:0]     row_idx;
    logic [127:0]   front;
    logic [127:0]   back;
    logic           cnt_last;
    logic           cnt_half;
    logic           frame_evt;
    logic           wr_accept;
    logic [6:0]     row_base;

    assign cnt_last  = (cnt == CW'(CLK_DIV - 1));
    assign cnt_half  = (cnt == CW'(CLK_DIV / 2 - 1));
    assign frame_evt = cnt_last && (row_idx == 3'd7);
    assign wr_accept = wr_valid && wr_ready;
    // Row 0 is the top row and sits in the most significant 16 bits.
    assign row_base  = {~wr_row, 4'b0000};

    // Scan divider: scan_clk falls mid-period and rises at wrap, advancing the scanned row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            scan_clk   <= 1'b0;
            row_idx    <= 3'd0;
            frame_tick <= 1'b0;
        end else begin
            cnt        <= cnt_last ? '0 : cnt + CW'(1);
            frame_tick <= frame_evt;
            if (cnt_half) begin
                scan_clk <= 1'b0;
            end
            if (cnt_last) begin
                scan_clk <= 1'b1;
                row_idx  <= row_idx + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // A commit seen in the same cycle as a frame event only arms the swap for the following frame.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (commit)    state_nx = SWAP_PEND;
            SWAP_PEND: if (frame_evt) state_nx = IDLE;
            default:                  state_nx = IDLE;
        endcase
    end

    always_comb begin
        wr_ready = 1'b1;
        busy     = 1'b0;
        if (state == SWAP_PEND) begin
            wr_ready = 1'b0;
            busy     = 1'b1;
        end
    end

    // Back buffer survives the swap so writers can edit incrementally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            back <= '0;
        end else if (wr_accept) begin
            back[row_base +: 16] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            front <= '0;
        end else if ((state == SWAP_PEND) && frame_evt) begin
            front <= back;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
        end else begin
            data_out <= blank ? '0 : front;
        end
    end

endmodule
